li_shell: RTL and testbench

Latency-insensitive shell that wraps a combinational two-operand pearl and connects it to the LI link fabric. It sits directly downstream of two relay-station chains (links A and B) and directly upstream of the next relay station. Per input, a small queue absorbs packets. The pearl fires only when both operands are present and the output register can accept a result; the registered result is presented on a single output link.

---
 rtl/li_pkg.sv | 14 +
 rtl/li_link.sv | 13 +
 rtl/li_queue.sv | 63 ++++++
 rtl/li_shell.sv | 108 ++++++++++
 tb/tb_li_shell.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/li_pkg.sv
// li_pkg: constants and helpers shared by the LI shell and its input queues.
//   LI_STALL_W   : width of the optional stall counter
//   LI_STALL_MAX : saturation value of the stall counter
//   li_count_w() : bits needed to hold an occupancy of 0..depth
package li_pkg;

  localparam int unsigned LI_STALL_W = 16;
  localparam logic [LI_STALL_W-1:0] LI_STALL_MAX = '1;

  function automatic int unsigned li_count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/li_link.sv
// li_link: one latency-insensitive link (data + valid forward, stop backward).
//   source modport : drives data/valid, observes stop
//   sink modport   : observes data/valid, drives stop
interface li_link #(
  parameter int unsigned WIDTH = 6
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             stop;

  modport source (output data, output valid, input stop);
  modport sink   (input data, input valid, output stop);
endinterface

// File: rtl/li_queue.sv
// li_queue: circular-buffer input queue of the LI shell.
//   clk, reset : clock, asynchronous active-high reset
//   push       : enqueue push_data this cycle (never asserted when full)
//   push_data  : packet payload
//   pop        : dequeue the head this cycle (never asserted when empty)
//   head       : oldest entry, forced to 0 when empty
//   count      : current occupancy
//   stop       : registered back-pressure, high while the queue is full
module li_queue
  import li_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head,
  output logic [li_count_w(DEPTH)-1:0]  count,
  output logic                          stop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = li_count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;

  always_comb begin
    cnt_next = cnt + CW'(push) - CW'(pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      stop   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt  <= cnt_next;
      // Stop is derived from the post-update occupancy so the upstream
      // relay station sees it one cycle after the filling push.
      stop <= (cnt_next == CW'(DEPTH));
    end
  end

  // Storage needs no reset: head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = (cnt != '0) ? mem[rd_ptr] : '0;
  assign count = cnt;

endmodule

// File: rtl/li_shell.sv
// li_shell: latency-insensitive shell around a combinational two-operand pearl.
//   clk, reset  : clock, asynchronous active-high reset
//   in_a, in_b  : operand links (sink side; stop is registered)
//   out_link    : registered result link (source side)
//   pearl_in_a/b: queue heads fed to the pearl (0 when empty)
//   pearl_out   : combinational pearl result
//   pearl_en    : fire strobe for stateful pearls
//   stall_count : saturating count of cycles with queued data but no fire;
//                 present only when LI_SHELL_STALL_COUNT_EN is defined
module li_shell
  import li_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  li_link.sink              in_a,
  li_link.sink              in_b,
  li_link.source            out_link,
  output logic [WIDTH-1:0]  pearl_in_a,
  output logic [WIDTH-1:0]  pearl_in_b,
  input  logic [WIDTH-1:0]  pearl_out,
  output logic              pearl_en
`ifdef LI_SHELL_STALL_COUNT_EN
  ,
  output logic [LI_STALL_W-1:0] stall_count
`endif
);

  localparam int unsigned CW = li_count_w(DEPTH);

  logic [CW-1:0] count_a;
  logic [CW-1:0] count_b;
  logic          push_a;
  logic          push_b;
  logic          out_ready;
  logic          fire;

  always_comb begin
    push_a = in_a.valid & ~in_a.stop;
    push_b = in_b.valid & ~in_b.stop;
  end

  li_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .push_data (in_a.data),
    .pop       (fire),
    .head      (pearl_in_a),
    .count     (count_a),
    .stop      (in_a.stop)
  );

  li_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .push_data (in_b.data),
    .pop       (fire),
    .head      (pearl_in_b),
    .count     (count_b),
    .stop      (in_b.stop)
  );

  // A void output may be overwritten even while downstream is stopping.
  always_comb begin
    out_ready = ~out_link.valid | ~out_link.stop;
    fire      = (count_a != '0) & (count_b != '0) & out_ready;
  end

  assign pearl_en = fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_link.valid <= 1'b0;
      out_link.data  <= '0;
    end else if (fire) begin
      out_link.valid <= 1'b1;
      out_link.data  <= pearl_out;
    end else if (out_link.valid && !out_link.stop) begin
      out_link.valid <= 1'b0;
    end
  end

`ifdef LI_SHELL_STALL_COUNT_EN
  logic [LI_STALL_W-1:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (((count_a != '0) || (count_b != '0)) && !fire &&
                 (stall_cnt != LI_STALL_MAX)) begin
      stall_cnt <= stall_cnt + LI_STALL_W'(1);
    end
  end

  assign stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_li_shell.sv
module tb_li_shell;

  localparam int unsigned W = 6;

  logic         clk;
  logic         reset;
  logic [W-1:0] pearl_in_a;
  logic [W-1:0] pearl_in_b;
  logic [W-1:0] pearl_out;
  logic         pearl_en;
`ifdef LI_SHELL_STALL_COUNT_EN
  logic [15:0]  stall_count;
`endif

  li_link #(.WIDTH(W)) a_if ();
  li_link #(.WIDTH(W)) b_if ();
  li_link #(.WIDTH(W)) o_if ();

  li_shell #(
    .WIDTH (W),
    .DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_a        (a_if),
    .in_b        (b_if),
    .out_link    (o_if),
    .pearl_in_a  (pearl_in_a),
    .pearl_in_b  (pearl_in_b),
    .pearl_out   (pearl_out),
    .pearl_en    (pearl_en)
`ifdef LI_SHELL_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  // Pearl under test: 6-bit adder.
  assign pearl_out = pearl_in_a + pearl_in_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_mis = 0;
  logic [W-1:0] src_a[$];
  logic [W-1:0] src_b[$];
  logic [W-1:0] exp_q[$];
  logic         want_stop = 1'b0;
  logic         acc_a = 1'b0;
  logic         acc_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    src_a.push_back(a);
    src_b.push_back(b);
    exp_q.push_back(a + b);
  endtask

  // Link A source: holds each packet until it is accepted (valid & ~stop).
  initial begin
    a_if.valid = 1'b0;
    a_if.data  = '0;
    forever begin
      @(negedge clk);
      acc_a = a_if.valid && !a_if.stop && !reset;
      @(posedge clk);
      #1;
      if (reset) begin
        acc_a = 1'b0;
        a_if.valid = 1'b0;
        a_if.data  = '0;
      end else begin
        if (acc_a && src_a.size() > 0) void'(src_a.pop_front());
        if (src_a.size() > 0) begin
          a_if.valid = 1'b1;
          a_if.data  = src_a[0];
        end else begin
          a_if.valid = 1'b0;
        end
      end
    end
  end

  // Link B source.
  initial begin
    b_if.valid = 1'b0;
    b_if.data  = '0;
    forever begin
      @(negedge clk);
      acc_b = b_if.valid && !b_if.stop && !reset;
      @(posedge clk);
      #1;
      if (reset) begin
        acc_b = 1'b0;
        b_if.valid = 1'b0;
        b_if.data  = '0;
      end else begin
        if (acc_b && src_b.size() > 0) void'(src_b.pop_front());
        if (src_b.size() > 0) begin
          b_if.valid = 1'b1;
          b_if.data  = src_b[0];
        end else begin
          b_if.valid = 1'b0;
        end
      end
    end
  end

  // Downstream stop changes only just after a rising edge.
  initial begin
    o_if.stop = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      o_if.stop = want_stop;
    end
  end

  // Monitor: every output transfer is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && o_if.valid === 1'b1 && o_if.stop === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL out_data: got %0d required no output", o_if.data);
        end else begin
          chk("out_data", o_if.data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset = 1'b1;
    nxt();
    nxt();
    chk("rst_out_valid", o_if.valid, 0);
    chk("rst_out_data", o_if.data, 0);
    chk("rst_a_stop", a_if.stop, 0);
    chk("rst_b_stop", b_if.stop, 0);
    chk("rst_pearl_en", pearl_en, 0);
    chk("rst_pearl_in_a", pearl_in_a, 0);
    chk("rst_pearl_in_b", pearl_in_b, 0);
    reset = 1'b0;
    nxt();

`ifdef LI_SHELL_STALL_COUNT_EN
    chk("stall_reset", stall_count, 0);
    src_a.push_back(6'd9);
    nxt();
    nxt();
    chk("stall_start", stall_count, 0);
    repeat (5) nxt();
    chk("stall_5", stall_count, 5);
    src_b.push_back(6'd0);
    exp_q.push_back(6'd9);
    repeat (4) nxt();
    force dut.stall_cnt = 16'hFFFD;
    #1;
    release dut.stall_cnt;
    src_a.push_back(6'd1);
    repeat (8) nxt();
    chk("stall_sat", stall_count, 16'hFFFF);
    src_b.push_back(6'd0);
    exp_q.push_back(6'd1);
    repeat (4) nxt();
`endif

    // Streaming: 2-cycle latency then one result per cycle.
    for (int i = 1; i <= 8; i++) send(W'(i), W'(i + 9));
    nxt();
    chk("stream_valid_p", o_if.valid, 0);
    nxt();
    chk("stream_valid_k", o_if.valid, 0);
    chk("stream_fire_k", pearl_en, 1);
    nxt();
    chk("stream_valid_k1", o_if.valid, 1);
    for (int i = 0; i < 8; i++) begin
      nxt();
      chk("stream_a_stop", a_if.stop, 0);
      chk("stream_b_stop", b_if.stop, 0);
    end
    repeat (3) nxt();

    // Starved operand B.
    src_a.push_back(6'd5);
    src_a.push_back(6'd6);
    repeat (4) nxt();
    chk("starve_a_stop", a_if.stop, 1);
    chk("starve_fire", pearl_en, 0);
    chk("starve_valid", o_if.valid, 0);
    src_b.push_back(6'd1);
    exp_q.push_back(6'd6);
    nxt();
    chk("starve_fire_p", pearl_en, 0);
    nxt();
    chk("starve_fire_m", pearl_en, 1);
    chk("starve_a_stop_m", a_if.stop, 1);
    nxt();
    chk("starve_valid_m1", o_if.valid, 1);
    chk("starve_a_stop_m1", a_if.stop, 0);
    src_b.push_back(6'd2);
    exp_q.push_back(6'd8);
    repeat (5) nxt();

    // Output back-pressure: result 9 held, queues fill, nothing lost.
    want_stop = 1'b1;
    send(6'd4, 6'd5);
    send(6'd1, 6'd1);
    send(6'd2, 6'd2);
    send(6'd3, 6'd3);
    repeat (10) nxt();
    chk("bp_valid", o_if.valid, 1);
    chk("bp_data", o_if.data, 9);
    chk("bp_a_stop", a_if.stop, 1);
    chk("bp_b_stop", b_if.stop, 1);
    chk("bp_fire", pearl_en, 0);
    want_stop = 1'b0;
    repeat (10) nxt();
    chk("bp_drained", exp_q.size(), 0);

    // Void overwrite while stopped.
    want_stop = 1'b1;
    send(6'd2, 6'd2);
    repeat (5) nxt();
    chk("void_valid", o_if.valid, 1);
    chk("void_data", o_if.data, 4);
    want_stop = 1'b0;
    repeat (3) nxt();

    // Reset mid-stream: held output plus two queued A packets discarded.
    want_stop = 1'b1;
    send(6'd30, 6'd1);
    src_a.push_back(6'd20);
    src_a.push_back(6'd21);
    repeat (8) nxt();
    chk("mid_valid", o_if.valid, 1);
    chk("mid_data", o_if.data, 31);
    chk("mid_a_stop", a_if.stop, 1);
    reset = 1'b1;
    #1;
    chk("mrst_out_valid", o_if.valid, 0);
    chk("mrst_out_data", o_if.data, 0);
    chk("mrst_a_stop", a_if.stop, 0);
    chk("mrst_b_stop", b_if.stop, 0);
    chk("mrst_pearl_en", pearl_en, 0);
    chk("mrst_pearl_in_a", pearl_in_a, 0);
    chk("mrst_pearl_in_b", pearl_in_b, 0);
    src_a.delete();
    src_b.delete();
    exp_q.delete();
    want_stop = 1'b0;
    nxt();
    reset = 1'b0;
    nxt();
    send(6'd3, 6'd4);
    repeat (6) nxt();

    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_src_a_empty", src_a.size(), 0);
    chk("end_src_b_empty", src_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
